// File: rtl/scan_alpha_pe.sv
// Alpha-update PE for the scan decoder: f/g min-sum over P lanes, chunked alpha RAM reads and writes.
// Define SCAN_PE_SAT_EN to clamp lane results to a symmetric range; otherwise they wrap to Q bits.
module scan_alpha_pe #(
  parameter int Q = 6,
  parameter int P = 64,
  parameter int N = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [4:0]     layer,
  input  logic [P*Q-1:0] a_left,
  input  logic [P*Q-1:0] a_right,
  input  logic [P*Q-1:0] beta_in,
  output logic           r_en,
  output logic [3:0]     cntb,
  output logic [4:0]     layer_r,
  output logic           w_en,
  output logic [4:0]     cnta,
  output logic [4:0]     layer_w,
  output logic [P*Q-1:0] a_out,
  output logic           busy,
  output logic           done
);

  localparam int W = Q + 2;
  localparam int MAX_LAYER = $clog2(N);
  localparam logic signed [W-1:0] SAT_HI = W'((1 << (Q - 1)) - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t         state;
  logic           op_q;
  logic [4:0]     layer_q;
  logic [3:0]     last_cnt;
  logic           v1;
  logic           last1;
  logic [3:0]     cnt1;
  logic [31:0]    span;
  logic [P*Q-1:0] next_out;

  function automatic logic [3:0] chunks_m1(input logic [4:0] lyr);
    int n;
    n = 1;
    if (lyr >= 5'd8) n = (1 << (lyr - 5'd1)) / P;
    if (n < 1) n = 1;
    return 4'(n - 1);
  endfunction

  function automatic logic signed [W-1:0] ms(input logic signed [W-1:0] x,
                                             input logic signed [W-1:0] y);
    logic signed [W-1:0] ax, ay, m;
    ax = x[W-1] ? -x : x;
    ay = y[W-1] ? -y : y;
    m  = (ax < ay) ? ax : ay;
    return (x[W-1] ^ y[W-1]) ? -m : m;
  endfunction

  function automatic logic [Q-1:0] lane_calc(input logic g, input logic [Q-1:0] lq,
                                             input logic [Q-1:0] rq, input logic [Q-1:0] bq);
    logic signed [W-1:0] l, r, b, res;
    l = {{2{lq[Q-1]}}, lq};
    r = {{2{rq[Q-1]}}, rq};
    b = {{2{bq[Q-1]}}, bq};
    res = g ? (r + ms(l, b)) : ms(l, r + b);
`ifdef SCAN_PE_SAT_EN
    if (res > SAT_HI) res = SAT_HI;
    else if (res < -SAT_HI) res = -SAT_HI;
`endif
    return res[Q-1:0];
  endfunction

  // Lanes beyond 2^(layer-1) carry no data and are forced to zero.
  always_comb begin
    next_out = '0;
    span = 32'd1 << (layer_q - 5'd1);
    for (int i = 0; i < P; i++) begin
      if (32'(i) < span)
        next_out[i*Q +: Q] = lane_calc(op_q, a_left[i*Q +: Q], a_right[i*Q +: Q], beta_in[i*Q +: Q]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 1'b0;
      layer_q  <= '0;
      last_cnt <= '0;
      v1       <= 1'b0;
      last1    <= 1'b0;
      cnt1     <= '0;
      r_en     <= 1'b0;
      cntb     <= '0;
      layer_r  <= '0;
      w_en     <= 1'b0;
      cnta     <= '0;
      layer_w  <= '0;
      a_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Read data returns one cycle after r_en and is computed straight into a_out.
      v1    <= r_en;
      cnt1  <= cntb;
      last1 <= r_en && (cntb == last_cnt);
      w_en  <= v1;
      done  <= v1 && last1;
      if (v1) begin
        a_out   <= next_out;
        cnta    <= {1'b0, cnt1};
        layer_w <= layer_q - 5'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (layer != 5'd0 && 32'(layer) <= MAX_LAYER) begin
              state    <= READ;
              op_q     <= op;
              layer_q  <= layer;
              last_cnt <= chunks_m1(layer);
              r_en     <= 1'b1;
              cntb     <= '0;
              layer_r  <= layer;
              busy     <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (cntb == last_cnt) begin
            r_en  <= 1'b0;
            state <= DRAIN;
          end else begin
            cntb <= cntb + 4'd1;
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_alpha_pe.sv
// Directed testbench for scan_alpha_pe; expectations follow SCAN_PE_SAT_EN when defined.
module tb_scan_alpha_pe;

  localparam int Q = 6;
  localparam int P = 64;
  localparam int N = 1024;

`ifdef SCAN_PE_SAT_EN
  localparam logic [Q-1:0] EXP_G_OVF = 6'h1F;
  localparam logic [Q-1:0] EXP_F_OVF = 6'h1F;
`else
  localparam logic [Q-1:0] EXP_G_OVF = 6'h33;
  localparam logic [Q-1:0] EXP_F_OVF = 6'h20;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           op;
  logic [4:0]     layer;
  logic [P*Q-1:0] a_left, a_right, beta_in;
  logic           r_en, w_en, busy, done;
  logic [3:0]     cntb;
  logic [4:0]     layer_r, cnta, layer_w;
  logic [P*Q-1:0] a_out;

  int errors = 0;
  int checks = 0;

  scan_alpha_pe #(.Q(Q), .P(P), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .layer(layer),
    .a_left(a_left), .a_right(a_right), .beta_in(beta_in),
    .r_en(r_en), .cntb(cntb), .layer_r(layer_r),
    .w_en(w_en), .cnta(cnta), .layer_w(layer_w),
    .a_out(a_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P*Q-1:0] fill(input int nl, input logic [Q-1:0] v, input logic [Q-1:0] other);
    logic [P*Q-1:0] r;
    for (int i = 0; i < P; i++) r[i*Q +: Q] = (i < nl) ? v : other;
    return r;
  endfunction

  // Launches an op and returns at the first sample where w_en is high (hit=0 on timeout).
  task automatic run_op(input logic f_op, input logic [4:0] lyr, output logic hit);
    op = f_op; layer = lyr; start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 12 && !hit; k++) begin
      if (w_en) hit = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_timeout busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; layer = 5'd0;
    a_left = '0; a_right = '0; beta_in = '0;
    tick(); tick();
    checks++;
    if ({r_en, w_en, done, busy} !== 4'b0 || a_out !== '0 || cntb !== 4'd0 || cnta !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_state r_en=%b w_en=%b done=%b busy=%b cntb=%0d cnta=%0d required all 0",
               r_en, w_en, done, busy, cntb, cnta);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_f_layer1();
    a_left  = fill(1, 6'd5, 6'd9);
    a_right = fill(1, 6'h3D, 6'd9);
    beta_in = fill(1, 6'd1, 6'd9);
    op = 1'b0; layer = 5'd1; start = 1'b1;
    tick();
    start = 1'b0; op = 1'b1; layer = 5'd5;
    checks++;
    if (r_en !== 1'b1 || cntb !== 4'd0 || layer_r !== 5'd1 || busy !== 1'b1 || w_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL f1_read r_en=%b cntb=%0d layer_r=%0d busy=%b w_en=%b required 1 0 1 1 0",
               r_en, cntb, layer_r, busy, w_en);
    end
    tick();
    checks++;
    if (r_en !== 1'b0 || w_en !== 1'b0) begin
      errors++; $display("[TB] FAIL f1_gap r_en=%b w_en=%b required 0 0", r_en, w_en);
    end
    tick();
    checks++;
    if (w_en !== 1'b1 || cnta !== 5'd0 || layer_w !== 5'd0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL f1_write w_en=%b cnta=%0d layer_w=%0d done=%b required 1 0 0 1", w_en, cnta, layer_w, done);
    end
    checks++;
    if (a_out[0 +: Q] !== 6'h3E || a_out[Q +: Q] !== 6'h00) begin
      errors++; $display("[TB] FAIL f1_data lane0=%h lane1=%h required 3e 00", a_out[0 +: Q], a_out[Q +: Q]);
    end
    tick();
    checks++;
    if (w_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL f1_end w_en=%b done=%b busy=%b required 0 0 0", w_en, done, busy);
    end
  endtask

  task automatic test_g_layer2();
    logic hit;
    int bad;
    a_left  = fill(2, 6'd5, 6'd7);
    a_right = fill(2, 6'h3D, 6'd7);
    beta_in = fill(2, 6'd1, 6'd7);
    run_op(1'b1, 5'd2, hit);
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL g2_timeout w_en=%b required 1", w_en); end
    bad = 0;
    for (int i = 0; i < P; i++)
      if (a_out[i*Q +: Q] !== ((i < 2) ? 6'h3E : 6'h00)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL g2_data lanes_wrong=%0d lane0=%h lane2=%h required 0 3e 00", bad, a_out[0 +: Q], a_out[2*Q +: Q]);
    end
    wait_idle();
  endtask

  task automatic test_layer10();
    int rd, wr, bsy, dn, bad;
    a_left  = fill(P, 6'd5, 6'd0);
    a_right = fill(P, 6'h3D, 6'd0);
    beta_in = fill(P, 6'd1, 6'd0);
    op = 1'b0; layer = 5'd10; start = 1'b1;
    tick();
    start = 1'b0;
    rd = 0; wr = 0; bsy = 0; dn = 0;
    for (int c = 0; c < 16; c++) begin
      if (r_en) begin
        checks++;
        if (cntb !== 4'(rd) || layer_r !== 5'd10) begin
          errors++; $display("[TB] FAIL l10_cntb cntb=%0d layer_r=%0d required %0d 10", cntb, layer_r, rd);
        end
        rd++;
      end
      if (w_en) begin
        checks++;
        if (cnta !== 5'(wr) || layer_w !== 5'd9) begin
          errors++; $display("[TB] FAIL l10_cnta cnta=%0d layer_w=%0d required %0d 9", cnta, layer_w, wr);
        end
        wr++;
      end
      if (busy) bsy++;
      if (done) begin
        dn++;
        checks++;
        if (cnta !== 5'd7 || w_en !== 1'b1) begin
          errors++; $display("[TB] FAIL l10_done cnta=%0d w_en=%b required 7 1", cnta, w_en);
        end
      end
      tick();
    end
    checks++;
    if (rd != 8 || wr != 8 || bsy != 10 || dn != 1) begin
      errors++; $display("[TB] FAIL l10_counts reads=%0d writes=%0d busy=%0d dones=%0d required 8 8 10 1", rd, wr, bsy, dn);
    end
    bad = 0;
    for (int i = 0; i < P; i++) if (a_out[i*Q +: Q] !== 6'h3E) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL l10_data lanes_wrong=%0d required 0", bad); end
  endtask

  task automatic test_overflow();
    logic hit;
    a_left = fill(1, 6'd20, 6'd0); a_right = fill(1, 6'd31, 6'd0); beta_in = fill(1, 6'd20, 6'd0);
    run_op(1'b1, 5'd1, hit);
    checks++;
    if (!hit || a_out[0 +: Q] !== EXP_G_OVF) begin
      errors++; $display("[TB] FAIL ovf_g hit=%b lane0=%h required %h", hit, a_out[0 +: Q], EXP_G_OVF);
    end
    wait_idle();
    a_left = fill(1, 6'h20, 6'd0); a_right = fill(1, 6'h20, 6'd0); beta_in = fill(1, 6'd0, 6'd0);
    run_op(1'b0, 5'd1, hit);
    checks++;
    if (!hit || a_out[0 +: Q] !== EXP_F_OVF) begin
      errors++; $display("[TB] FAIL ovf_f hit=%b lane0=%h required %h", hit, a_out[0 +: Q], EXP_F_OVF);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int wr, dn;
    op = 1'b0; layer = 5'd9; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wr = 0; dn = 0;
    for (int c = 0; c < 16; c++) begin
      if (w_en) wr++;
      if (done) dn++;
      tick();
    end
    checks++;
    if (wr != 4 || dn != 1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b writes=%0d dones=%0d busy=%b required 4 1 0", wr, dn, busy);
    end
  endtask

  task automatic test_bad_layer();
    logic [4:0] bad_layers [2];
    int stray;
    bad_layers[0] = 5'd0; bad_layers[1] = 5'd11;
    for (int t = 0; t < 2; t++) begin
      layer = bad_layers[t]; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || r_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL bad_layer_%0d done=%b r_en=%b busy=%b required 1 0 0", bad_layers[t], done, r_en, busy);
      end
      stray = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (done || r_en || w_en) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("[TB] FAIL bad_layer_quiet_%0d stray=%0d required 0", bad_layers[t], stray); end
    end
  endtask

  task automatic test_reset_abort();
    int wr, stray;
    logic hit;
    op = 1'b0; layer = 5'd10; start = 1'b1;
    tick();
    start = 1'b0;
    wr = 0;
    for (int c = 0; c < 12 && wr < 3; c++) begin
      tick();
      if (w_en) wr++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r_en, w_en, done, busy} !== 4'b0 || a_out !== '0 || cntb !== 4'd0 || cnta !== 5'd0 ||
        layer_r !== 5'd0 || layer_w !== 5'd0 || wr != 3) begin
      errors++;
      $display("[TB] FAIL abort_outputs r_en=%b w_en=%b done=%b busy=%b cntb=%0d cnta=%0d writes=%0d required 0s and 3",
               r_en, w_en, done, busy, cntb, cnta, wr);
    end
    tick();
    stray = 0;
    if (w_en || busy) stray++;
    a_left = fill(1, 6'd5, 6'd0); a_right = fill(1, 6'h3D, 6'd0); beta_in = fill(1, 6'd1, 6'd0);
    rst = 1'b0;
    run_op(1'b0, 5'd1, hit);
    checks++;
    if (stray != 0 || !hit || a_out[0 +: Q] !== 6'h3E || layer_w !== 5'd0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_restart stray=%0d hit=%b lane0=%h layer_w=%0d done=%b required 0 1 3e 0 1",
               stray, hit, a_out[0 +: Q], layer_w, done);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_f_layer1();
    test_g_layer2();
    test_layer10();
    test_overflow();
    test_back_to_back();
    test_bad_layer();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_alpha_pe.md
SCAN_ALPHA_PE -- requirements
Module: scan_alpha_pe

Interface
REQ-001 SHALL have parameter Q, default 6, LLR width in bits (signed two's complement).
REQ-002 SHALL have parameter P, default 64, processing lanes per chunk.
REQ-003 SHALL have parameter N, default 1024, code length.
REQ-004 SHALL have one clock; reset is asynchronous and active-high: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-005 SHALL have ports:
- start  in  1  launch one layer update.
- op  in  1  function select: 0 = f, 1 = g.
- layer  in  5  source layer 1..10.
- a_left  in  P*Q  left alpha chunk from alpha RAM.
- a_right  in  P*Q  right alpha chunk from alpha RAM.
- beta_in  in  P*Q  soft beta chunk, aligned with a_left/a_right.
- r_en  out  1  alpha RAM read enable.
- cntb  out  4  read chunk count.
- layer_r  out  5  read layer.
- w_en  out  1  alpha RAM write enable.
- cnta  out  5  write chunk count.
- layer_w  out  5  write layer.
- a_out  out  P*Q  computed alpha chunk.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL compute per lane i, with all arithmetic in Q+2 bits: ms(x,y) = sign(x)*sign(y)*min(|x|,|y|); f: out = ms(L_i, R_i + B_i); g: out = R_i + ms(L_i, B_i).
REQ-007 SHALL treat zero as positive in sign().
REQ-008 SHALL use chunk count n = 2^(layer-1)/P when layer >= 8, else n = 1.
REQ-009 SHALL use active lanes = min(P, 2^(layer-1)); inactive lanes of a_out SHALL be 0.
REQ-010 SHALL have FSM states IDLE, READ, DRAIN:
- IDLE -> READ on start with layer in 1..10.
- READ -> DRAIN after n reads issued.
- DRAIN -> IDLE after last write.
REQ-011 SHALL, in READ, register r_en=1 for exactly n consecutive cycles, with cntb = 0..n-1 ascending and layer_r = layer; the first r_en cycle is the cycle after the start edge.
REQ-012 SHALL sample a_left, a_right and beta_in on the edge after each r_en cycle (RAM read latency 1).
REQ-013 SHALL register a_out and assert w_en, with cnta = matching cntb and layer_w = layer-1, exactly 2 cycles after the corresponding r_en cycle.
REQ-014 SHALL assert done for one cycle concurrent with the last w_en.
REQ-015 SHALL hold busy high from the first r_en cycle through the last w_en cycle inclusive.
REQ-016 SHALL latch op and layer at start; input changes during busy SHALL have no effect.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL, when start arrives with layer 0 or layer >10, issue no r_en or w_en and pulse done in the next cycle.
REQ-019 SHALL drive r_en, w_en and done to 0 in every cycle not specified above; a_out SHALL hold its last value.

Reset
REQ-020 SHALL, on rst, immediately force state IDLE and drive r_en, w_en, done, busy, cntb, cnta, layer_r, layer_w and a_out to 0, aborting any operation with no further writes.
REQ-021 SHALL accept start on the first clk edge after rst deasserts.

Configuration
REQ-022 SHALL, with macro SCAN_PE_SAT_EN defined, clamp each lane result to the symmetric range [-(2^(Q-1)-1), +(2^(Q-1)-1)].
REQ-023 SHALL, without SCAN_PE_SAT_EN, truncate each lane result to its low Q bits (two's-complement wrap); the -2^(Q-1) code may appear.

Verification
REQ-024 SHALL cover f at layer 1, lane 0 with L=5, R=-3, B=1 -> single r_en (cntb=0, layer_r=1); w_en 2 cycles later with layer_w=0, a_out lane0 = -2, lane1 = 0, done high with w_en.
REQ-025 SHALL cover g at layer 2 with L=5, R=-3, B=1 on lanes 0-1 -> a_out lanes 0-1 = -2, lanes 2-63 = 0.
REQ-026 SHALL cover f at layer 10 -> 8 r_en cycles with cntb 0..7, 8 w_en cycles with cnta 0..7 and layer_w=9, busy high for 10 cycles, done with cnta=7.
REQ-027 SHALL cover g with R=31, L=20, B=20 -> a_out = 31 with SCAN_PE_SAT_EN, -13 without; f with L=-32, R=-32, B=0 -> 31 with SCAN_PE_SAT_EN, -32 without.
REQ-028 SHALL cover a second start (layer 9) in the cycle after a first start (layer 9) -> second ignored, exactly 4 writes, a single done.
REQ-029 SHALL cover rst asserted after the 3rd w_en of a layer-10 op -> all outputs 0 immediately, no further w_en, busy low; a new start then runs normally.
